// File: rtl/modulation_az_seq_pkg.sv
// Shared definitions for the auto-zero modulation sequencer: switch polarities,
// clock frequency, FSM state encoding and monitor bit positions.
package modulation_az_seq_pkg;

  localparam logic SW_PC_SIGNAL = 1'b1;
  localparam logic SW_PC_BOOT   = 1'b0;

  localparam int CLK_FREQ          = 20_000_000;
  localparam int ADC_TIMEOUT_MS    = 200;
  localparam int ADC_TIMEOUT_CLKS  = (CLK_FREQ / 1000) * ADC_TIMEOUT_MS;

  localparam int MON_AZ_HI = 0;
  localparam int MON_TRIG  = 1;
  localparam int MON_ERR   = 2;
  localparam int MON_IS_LO = 3;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_START,
    ST_SETTLE_HI,
    ST_TRIG_HI,
    ST_WAIT_HI,
    ST_PROTECT,
    ST_SETTLE_LO,
    ST_TRIG_LO,
    ST_WAIT_LO,
    ST_DONE,
    ST_ERR
  } state_t;

endpackage

// File: rtl/modulation_az_seq_phase_timer.sv
// Loadable down-counter for phase durations; holds at zero until reloaded.
module modulation_az_seq_phase_timer #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] value,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= value;
    end else if (cnt_reg != '0) begin
      cnt_reg <= cnt_reg - 1'b1;
    end
  end

  assign zero = (cnt_reg == '0);

endmodule

// File: rtl/modulation_az_seq.sv
// Auto-zero modulation sequencer: settles, triggers HI and optional LO ADC
// conversions, and reports each completed cycle to the MCU.
module modulation_az_seq
  import modulation_az_seq_pkg::*;
#(
  parameter int AZMUX_W      = 4,
  parameter int PC_W         = 24,
  parameter int CNT_W        = 32,
  parameter int TIMEOUT_CLKS = ADC_TIMEOUT_CLKS,
  parameter int SCOUNT_W     = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  input  logic                az_en,
  input  logic [AZMUX_W-1:0]  azmux_hi_val,
  input  logic [AZMUX_W-1:0]  azmux_lo_val,
  input  logic [PC_W-1:0]     precharge_n,
  input  logic                adc_measure_valid,
  output logic                adc_measure_trig,
  output logic                sw_pc_ctl,
  output logic [AZMUX_W-1:0]  azmux,
  output logic                is_lo,
  output logic                led0,
  output logic [3:0]          monitor,
  output logic                spi_interrupt_ctl,
  output logic [SCOUNT_W-1:0] sample_count,
  output logic                err
);

  state_t state_reg, state_next;

  logic               timer_load;
  logic [CNT_W-1:0]   timer_value;
  logic               timer_zero;
  logic               adc_done;

  logic               az_en_reg;
  logic [AZMUX_W-1:0] lo_reg;
  logic [PC_W-1:0]    pc_reg;

  logic               trig_reg;
  logic               sw_pc_reg;
  logic [AZMUX_W-1:0] azmux_reg;
  logic               az_hi_reg;
  logic               is_lo_reg;
  logic               led_reg;
  logic               spi_reg;
  logic [SCOUNT_W-1:0] count_reg;
  logic               err_reg;

  modulation_az_seq_phase_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .load  (timer_load),
    .value (timer_value),
    .zero  (timer_zero)
  );

  // A valid still high from the previous result is never taken as this conversion's result.
  assign adc_done = adc_measure_valid && !trig_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    timer_load  = 1'b0;
    timer_value = CNT_W'(pc_reg);
    case (state_reg)
      ST_IDLE:      if (run) state_next = ST_START;
      ST_START: begin
        timer_load = 1'b1;
        state_next = ST_SETTLE_HI;
      end
      ST_SETTLE_HI: if (timer_zero) state_next = ST_TRIG_HI;
      ST_TRIG_HI: begin
        timer_load  = 1'b1;
        timer_value = CNT_W'(TIMEOUT_CLKS);
        state_next  = ST_WAIT_HI;
      end
      ST_WAIT_HI: begin
        if (adc_done)        state_next = az_en_reg ? ST_PROTECT : ST_DONE;
        else if (timer_zero) state_next = ST_ERR;
      end
      ST_PROTECT: begin
        timer_load = 1'b1;
        state_next = ST_SETTLE_LO;
      end
      ST_SETTLE_LO: if (timer_zero) state_next = ST_TRIG_LO;
      ST_TRIG_LO: begin
        timer_load  = 1'b1;
        timer_value = CNT_W'(TIMEOUT_CLKS);
        state_next  = ST_WAIT_LO;
      end
      ST_WAIT_LO: begin
        if (adc_done)        state_next = ST_DONE;
        else if (timer_zero) state_next = ST_ERR;
      end
      ST_DONE:      state_next = run ? ST_START : ST_IDLE;
      ST_ERR:       if (!run) state_next = ST_IDLE;
      default:      state_next = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      az_en_reg <= 1'b0;
      lo_reg    <= '0;
      pc_reg    <= '0;
      trig_reg  <= 1'b0;
      sw_pc_reg <= SW_PC_BOOT;
      azmux_reg <= '0;
      az_hi_reg <= 1'b0;
      is_lo_reg <= 1'b0;
      led_reg   <= 1'b0;
      spi_reg   <= 1'b0;
      count_reg <= '0;
      err_reg   <= 1'b0;
    end else begin
      trig_reg <= (state_next == ST_TRIG_HI) || (state_next == ST_TRIG_LO);
      case (state_next)
        ST_IDLE: begin
          sw_pc_reg <= SW_PC_BOOT;
          azmux_reg <= lo_reg;
          az_hi_reg <= 1'b0;
        end
        ST_START: begin
          az_en_reg <= az_en;
          lo_reg    <= azmux_lo_val;
          pc_reg    <= precharge_n;
          err_reg   <= 1'b0;
          sw_pc_reg <= SW_PC_BOOT;
          azmux_reg <= azmux_hi_val;
          az_hi_reg <= 1'b1;
        end
        ST_TRIG_HI: begin
          sw_pc_reg <= SW_PC_SIGNAL;
          is_lo_reg <= 1'b0;
          spi_reg   <= 1'b0;
        end
        ST_PROTECT: sw_pc_reg <= SW_PC_BOOT;
        ST_TRIG_LO: begin
          azmux_reg <= lo_reg;
          az_hi_reg <= 1'b0;
          is_lo_reg <= 1'b1;
        end
        ST_DONE: begin
          count_reg <= count_reg + 1'b1;
          led_reg   <= ~led_reg;
          spi_reg   <= 1'b1;
        end
        ST_ERR: begin
          err_reg   <= 1'b1;
          sw_pc_reg <= SW_PC_BOOT;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    monitor            = '0;
    monitor[MON_AZ_HI] = az_hi_reg;
    monitor[MON_TRIG]  = trig_reg;
    monitor[MON_ERR]   = err_reg;
    monitor[MON_IS_LO] = is_lo_reg;
  end

  assign adc_measure_trig  = trig_reg;
  assign sw_pc_ctl         = sw_pc_reg;
  assign azmux             = azmux_reg;
  assign is_lo             = is_lo_reg;
  assign led0              = led_reg;
  assign spi_interrupt_ctl = spi_reg;
  assign sample_count      = count_reg;
  assign err               = err_reg;

endmodule

// File: tb/tb_modulation_az_seq.sv
// Self-checking bench for modulation_az_seq: an ADC model answers triggers and
// expected timing is derived from the settle/conversion delay arithmetic.
module tb_modulation_az_seq;

  localparam int TIMEOUT = 200;

  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic        az_en;
  logic [3:0]  azmux_hi_val;
  logic [3:0]  azmux_lo_val;
  logic [23:0] precharge_n;
  logic        adc_measure_valid = 1'b0;
  logic        adc_measure_trig;
  logic        sw_pc_ctl;
  logic [3:0]  azmux;
  logic        is_lo;
  logic        led0;
  logic [3:0]  monitor;
  logic        spi_interrupt_ctl;
  logic [15:0] sample_count;
  logic        err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int adc_delay = 4;
  bit adc_on = 1'b1;
  int adc_cnt = 0;
  bit adc_busy = 1'b0;

  modulation_az_seq #(
    .AZMUX_W(4), .PC_W(24), .CNT_W(32), .TIMEOUT_CLKS(TIMEOUT), .SCOUNT_W(16)
  ) dut (
    .clk(clk), .reset(reset), .run(run), .az_en(az_en),
    .azmux_hi_val(azmux_hi_val), .azmux_lo_val(azmux_lo_val),
    .precharge_n(precharge_n), .adc_measure_valid(adc_measure_valid),
    .adc_measure_trig(adc_measure_trig), .sw_pc_ctl(sw_pc_ctl), .azmux(azmux),
    .is_lo(is_lo), .led0(led0), .monitor(monitor),
    .spi_interrupt_ctl(spi_interrupt_ctl), .sample_count(sample_count), .err(err)
  );

  always #25 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // ADC controller model: clears valid on trig, raises it adc_delay clocks later and holds it.
  always @(negedge clk) begin
    if (reset) begin
      adc_measure_valid = 1'b0;
      adc_busy = 1'b0;
    end else if (adc_measure_trig) begin
      adc_measure_valid = 1'b0;
      adc_cnt = adc_delay;
      adc_busy = adc_on;
    end else if (adc_busy) begin
      adc_cnt--;
      if (adc_cnt <= 0) begin
        adc_measure_valid = 1'b1;
        adc_busy = 1'b0;
      end
    end
  end

  task automatic wait_trig(input int limit, output int t, output bit ok);
    ok = 1'b0;
    t = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (adc_measure_trig === 1'b1) begin
        t = cyc;
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_count(input logic [15:0] old, input int limit, output int t, output bit ok);
    ok = 1'b0;
    t = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (sample_count !== old) begin
        t = cyc;
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if (sw_pc_ctl !== 1'b0) begin errors++; $display("FAIL reset_sw_pc got %0b exp 0", sw_pc_ctl); end
    checks++; if (azmux !== 4'h0) begin errors++; $display("FAIL reset_azmux got %0h exp 0", azmux); end
    checks++; if (adc_measure_trig !== 1'b0) begin errors++; $display("FAIL reset_trig got %0b exp 0", adc_measure_trig); end
    checks++; if (is_lo !== 1'b0 || led0 !== 1'b0) begin errors++; $display("FAIL reset_islo_led got %0b%0b exp 00", is_lo, led0); end
    checks++; if (monitor !== 4'h0) begin errors++; $display("FAIL reset_monitor got %0h exp 0", monitor); end
    checks++; if (spi_interrupt_ctl !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL reset_spi_err got %0b%0b exp 00", spi_interrupt_ctl, err); end
    checks++; if (sample_count !== 16'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", sample_count); end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (adc_measure_trig !== 1'b0 || sample_count !== 16'd0) begin errors++; $display("FAIL idle_no_run got trig=%0b count=%0d exp 0/0", adc_measure_trig, sample_count); end
  endtask

  task automatic test_az_cycle();
    int k, t1, t2, td;
    bit ok;
    logic [3:0] hi, lo;
    logic [15:0] cnt0;
    logic led_prev;
    hi = 4'($urandom_range(1, 15));
    lo = hi ^ 4'($urandom_range(1, 15));
    @(negedge clk);
    az_en = 1'b1; azmux_hi_val = hi; azmux_lo_val = lo; precharge_n = 24'd10;
    adc_delay = 48; adc_on = 1'b1;
    cnt0 = sample_count; led_prev = led0; k = cyc; run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    wait_trig(40, t1, ok);
    checks++; if (!ok || t1 != k + 13) begin errors++; $display("FAIL az_hi_trig_latency got %0d exp %0d", t1 - k, 13); end
    checks++; if (azmux !== hi || sw_pc_ctl !== 1'b1 || is_lo !== 1'b0) begin errors++; $display("FAIL az_hi_outputs got azmux=%0h sw=%0b lo=%0b exp %0h/1/0", azmux, sw_pc_ctl, is_lo, hi); end
    checks++; if (monitor !== 4'b0011 || spi_interrupt_ctl !== 1'b0) begin errors++; $display("FAIL az_hi_monitor got %b spi=%0b exp 0011 spi=0", monitor, spi_interrupt_ctl); end
    wait_trig(100, t2, ok);
    checks++; if (!ok || t2 != t1 + 48 + 13) begin errors++; $display("FAIL az_lo_trig_latency got %0d exp %0d", t2 - t1, 61); end
    checks++; if (azmux !== lo || sw_pc_ctl !== 1'b0 || is_lo !== 1'b1) begin errors++; $display("FAIL az_lo_outputs got azmux=%0h sw=%0b lo=%0b exp %0h/0/1", azmux, sw_pc_ctl, is_lo, lo); end
    checks++; if (monitor !== 4'b1010) begin errors++; $display("FAIL az_lo_monitor got %b exp 1010", monitor); end
    wait_count(cnt0, 80, td, ok);
    checks++; if (!ok || td != t2 + 49) begin errors++; $display("FAIL az_done_cycle got %0d exp %0d", td - t2, 49); end
    checks++; if (sample_count !== cnt0 + 16'd1 || led0 !== ~led_prev || spi_interrupt_ctl !== 1'b1) begin errors++; $display("FAIL az_done_outputs got count=%0d led=%0b spi=%0b exp %0d/%0b/1", sample_count, led0, spi_interrupt_ctl, cnt0 + 16'd1, ~led_prev); end
    repeat (3) @(negedge clk);
    checks++; if (azmux !== lo || sw_pc_ctl !== 1'b0 || adc_measure_trig !== 1'b0) begin errors++; $display("FAIL az_idle got azmux=%0h sw=%0b exp %0h/0", azmux, sw_pc_ctl, lo); end
  endtask

  task automatic test_hi_only();
    int pc, d, t, tprev, n;
    bit ok;
    logic [3:0] hi;
    logic [15:0] cnt0;
    logic led_prev;
    pc = $urandom_range(1, 8);
    d = $urandom_range(2, 10);
    hi = 4'($urandom_range(1, 15));
    tprev = 0;
    @(negedge clk);
    az_en = 1'b0; azmux_hi_val = hi; azmux_lo_val = ~hi; precharge_n = 24'(pc);
    adc_delay = d; adc_on = 1'b1;
    cnt0 = sample_count; led_prev = led0; run = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wait_trig(d + pc + 20, t, ok);
      checks++; if (!ok || azmux !== hi || is_lo !== 1'b0) begin errors++; $display("FAIL hi_only_trig%0d got ok=%0b azmux=%0h lo=%0b exp 1/%0h/0", i, ok, azmux, is_lo, hi); end
      if (i > 0) begin
        checks++; if (t - tprev != d + pc + 4) begin errors++; $display("FAIL hi_only_period%0d got %0d exp %0d", i, t - tprev, d + pc + 4); end
      end
      tprev = t;
      if (i == 4) run = 1'b0;
    end
    for (int i = 0; i < 100 && sample_count !== cnt0 + 16'd5; i++) @(negedge clk);
    checks++; if (sample_count !== cnt0 + 16'd5 || led0 !== ~led_prev) begin errors++; $display("FAIL hi_only_count got %0d led=%0b exp %0d/%0b", sample_count, led0, cnt0 + 16'd5, ~led_prev); end
    n = 0;
    repeat (40) begin @(negedge clk); if (adc_measure_trig === 1'b1) n++; end
    checks++; if (n != 0) begin errors++; $display("FAIL hi_only_stop got %0d extra trigs exp 0", n); end
  endtask

  task automatic test_random_cycles();
    int k, t1, t2, td, pc, d;
    bit ok, az;
    logic [3:0] hi, lo;
    logic [15:0] cnt0;
    logic led_prev;
    for (int it = 0; it < 6; it++) begin
      az = (it == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      pc = (it == 0) ? 0 : $urandom_range(0, 15);
      d = $urandom_range(1, 20);
      hi = 4'($urandom_range(1, 15));
      lo = hi ^ 4'($urandom_range(1, 15));
      @(negedge clk);
      az_en = az; azmux_hi_val = hi; azmux_lo_val = lo; precharge_n = 24'(pc);
      adc_delay = d; adc_on = 1'b1;
      cnt0 = sample_count; led_prev = led0; k = cyc; run = 1'b1;
      @(negedge clk);
      run = 1'b0;
      wait_trig(pc + 10, t1, ok);
      checks++; if (!ok || t1 != k + pc + 3) begin errors++; $display("FAIL rnd%0d_hi_latency got %0d exp %0d", it, t1 - k - 1, pc + 2); end
      checks++; if (azmux !== hi || is_lo !== 1'b0 || sw_pc_ctl !== 1'b1) begin errors++; $display("FAIL rnd%0d_hi_outputs got azmux=%0h lo=%0b sw=%0b exp %0h/0/1", it, azmux, is_lo, sw_pc_ctl, hi); end
      t2 = t1;
      if (az) begin
        wait_trig(d + pc + 10, t2, ok);
        checks++; if (!ok || t2 != t1 + d + pc + 3) begin errors++; $display("FAIL rnd%0d_lo_latency got %0d exp %0d", it, t2 - t1 - d, pc + 3); end
        checks++; if (azmux !== lo || is_lo !== 1'b1 || sw_pc_ctl !== 1'b0) begin errors++; $display("FAIL rnd%0d_lo_outputs got azmux=%0h lo=%0b sw=%0b exp %0h/1/0", it, azmux, is_lo, sw_pc_ctl, lo); end
      end
      wait_count(cnt0, d + 10, td, ok);
      checks++; if (!ok || td != t2 + d + 1) begin errors++; $display("FAIL rnd%0d_done_cycle got %0d exp %0d", it, td - t2, d + 1); end
      checks++; if (sample_count !== cnt0 + 16'd1 || led0 !== ~led_prev || spi_interrupt_ctl !== 1'b1) begin errors++; $display("FAIL rnd%0d_done_outputs got count=%0d led=%0b spi=%0b exp %0d/%0b/1", it, sample_count, led0, spi_interrupt_ctl, cnt0 + 16'd1, ~led_prev); end
      repeat (2) @(negedge clk);
      checks++; if (azmux !== lo || sw_pc_ctl !== 1'b0 || adc_measure_trig !== 1'b0) begin errors++; $display("FAIL rnd%0d_idle got azmux=%0h sw=%0b exp %0h/0", it, azmux, sw_pc_ctl, lo); end
    end
  endtask

  task automatic test_timeout();
    int t, td, n;
    bit ok;
    logic [15:0] cnt0;
    @(negedge clk);
    az_en = 1'b1; azmux_hi_val = 4'h3; azmux_lo_val = 4'hC; precharge_n = 24'd3;
    adc_on = 1'b0;
    cnt0 = sample_count; run = 1'b1;
    wait_trig(20, t, ok);
    checks++; if (!ok) begin errors++; $display("FAIL to_trig got none exp trig"); end
    while (cyc < t + TIMEOUT) @(negedge clk);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL to_err_early got %0b exp 0", err); end
    repeat (2) @(negedge clk);
    checks++; if (err !== 1'b1 || monitor[2] !== 1'b1) begin errors++; $display("FAIL to_err_set got %0b mon=%b exp 1", err, monitor); end
    checks++; if (sw_pc_ctl !== 1'b0 || adc_measure_trig !== 1'b0) begin errors++; $display("FAIL to_outputs got sw=%0b trig=%0b exp 0/0", sw_pc_ctl, adc_measure_trig); end
    checks++; if (sample_count !== cnt0) begin errors++; $display("FAIL to_count got %0d exp %0d", sample_count, cnt0); end
    n = 0;
    repeat (20) begin @(negedge clk); if (adc_measure_trig === 1'b1) n++; end
    checks++; if (n != 0 || err !== 1'b1) begin errors++; $display("FAIL to_held got trigs=%0d err=%0b exp 0/1", n, err); end
    run = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL to_sticky_idle got %0b exp 1", err); end
    adc_on = 1'b1; adc_delay = 4; run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL to_err_clear got %0b exp 0", err); end
    wait_count(cnt0, 60, td, ok);
    checks++; if (!ok || sample_count !== cnt0 + 16'd1) begin errors++; $display("FAIL to_recover got %0d exp %0d", sample_count, cnt0 + 16'd1); end
  endtask

  task automatic test_run_drop();
    int t1, t2, td, n;
    bit ok, spi_held;
    logic [15:0] cnt0;
    @(negedge clk);
    az_en = 1'b1; azmux_hi_val = 4'hA; azmux_lo_val = 4'h5; precharge_n = 24'd4;
    adc_delay = 30; adc_on = 1'b1;
    cnt0 = sample_count; run = 1'b1;
    wait_trig(20, t1, ok);
    checks++; if (!ok) begin errors++; $display("FAIL drop_hi_trig got none exp trig"); end
    repeat (10) @(negedge clk);
    run = 1'b0;
    wait_trig(50, t2, ok);
    checks++; if (!ok || t2 != t1 + 37 || is_lo !== 1'b1) begin errors++; $display("FAIL drop_lo_trig got %0d lo=%0b exp 37/1", t2 - t1, is_lo); end
    wait_count(cnt0, 50, td, ok);
    checks++; if (!ok || sample_count !== cnt0 + 16'd1) begin errors++; $display("FAIL drop_count got %0d exp %0d", sample_count, cnt0 + 16'd1); end
    n = 0; spi_held = 1'b1;
    repeat (60) begin
      @(negedge clk);
      if (adc_measure_trig === 1'b1) n++;
      if (spi_interrupt_ctl !== 1'b1) spi_held = 1'b0;
    end
    checks++; if (n != 0) begin errors++; $display("FAIL drop_idle got %0d trigs exp 0", n); end
    checks++; if (!spi_held) begin errors++; $display("FAIL drop_spi got low exp held 1"); end
  endtask

  task automatic test_reset_mid();
    int t1, td, k;
    bit ok;
    @(negedge clk);
    az_en = 1'b1; azmux_hi_val = 4'h9; azmux_lo_val = 4'h6; precharge_n = 24'd20;
    adc_delay = 5; adc_on = 1'b1; run = 1'b1;
    wait_trig(40, t1, ok);
    for (int i = 0; i < 20 && adc_measure_valid !== 1'b1; i++) @(negedge clk);
    repeat (6) @(negedge clk);
    checks++; if (azmux !== 4'h9 || sample_count === 16'd0) begin errors++; $display("FAIL rmid_pre got azmux=%0h count=%0d exp 9/nonzero", azmux, sample_count); end
    reset = 1'b1; run = 1'b0;
    #1;
    checks++; if ({sw_pc_ctl, azmux, adc_measure_trig, is_lo, led0, monitor, spi_interrupt_ctl, err} !== 13'd0) begin errors++; $display("FAIL rmid_outputs got %b exp 0", {sw_pc_ctl, azmux, adc_measure_trig, is_lo, led0, monitor, spi_interrupt_ctl, err}); end
    checks++; if (sample_count !== 16'd0) begin errors++; $display("FAIL rmid_count got %0d exp 0", sample_count); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    az_en = 1'b0; precharge_n = 24'd2; adc_delay = 3; k = cyc; run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    wait_trig(20, t1, ok);
    checks++; if (!ok || t1 != k + 5) begin errors++; $display("FAIL rmid_restart_trig got %0d exp 5", t1 - k); end
    wait_count(16'd0, 20, td, ok);
    checks++; if (!ok || sample_count !== 16'd1 || led0 !== 1'b1) begin errors++; $display("FAIL rmid_restart_done got %0d led=%0b exp 1/1", sample_count, led0); end
  endtask

  initial begin
    reset = 1'b1; run = 1'b0; az_en = 1'b0;
    azmux_hi_val = 4'h0; azmux_lo_val = 4'h0; precharge_n = 24'd0;
    test_reset();
    test_az_cycle();
    test_hi_only();
    test_random_cycles();
    test_timeout();
    test_run_drop();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got time limit exp finish");
    $fatal(1, "watchdog");
  end

endmodule
